fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core. Owns the program counter, issues word requests to instruction memory, buffers returned instructions in a 2-entry FIFO, and presents them to decode with a valid/ready handshake. It consumes the branch decision `take_branch_i` and the branch target from execute. A taken branch redirects the PC, flushes the buffer and squashes every response still in flight.

---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory and
// buffers returned words in a 2-entry FIFO toward decode; a taken branch squashes in-flight data.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,

    input  logic        take_branch_i,
    input  logic [31:0] branch_target_i,

    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0] fetch_pc_q;
    logic [31:0] head_pc_q;
    logic [31:0] fifo_q [2];
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  outstanding_q;
    logic [1:0]  discard_q;

    logic        pop;
    logic        issue;
    logic        rsp;
    logic        push;
    logic        wr_ptr;
    logic [2:0]  occupancy;
    logic [31:0] target_pc;

    always_comb begin
        instr_valid_o = rst_ni && (count_q != 2'd0) && !take_branch_i;
        pop           = instr_valid_o && instr_ready_i;
        // Words in flight plus buffered must never exceed the FIFO depth.
        occupancy     = {1'b0, outstanding_q} + {1'b0, count_q} - {2'b00, pop};
        imem_req_o    = rst_ni && !take_branch_i && (occupancy < 3'd2);
        issue         = imem_req_o && imem_gnt_i;
        // A response with nothing outstanding is a protocol violation and is ignored.
        rsp           = rst_ni && imem_rvalid_i && (outstanding_q != 2'd0);
        push          = rsp && (discard_q == 2'd0) && !take_branch_i;
        wr_ptr        = rd_ptr_q ^ (count_q != 2'd0);
        target_pc     = branch_target_i & 32'hFFFF_FFFC;
    end

    assign imem_addr_o = fetch_pc_q;
    assign instr_o     = fifo_q[rd_ptr_q];
    assign instr_pc_o  = head_pc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_ADDR;
            head_pc_q     <= RESET_ADDR;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
        end else if (take_branch_i) begin
            fetch_pc_q    <= target_pc;
            head_pc_q     <= target_pc;
            count_q       <= 2'd0;
            // Every response still in flight after this edge belongs to the old path.
            outstanding_q <= outstanding_q - {1'b0, rsp};
            discard_q     <= outstanding_q - {1'b0, rsp};
        end else begin
            if (issue) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (pop) begin
                head_pc_q <= head_pc_q + 32'd4;
                rd_ptr_q  <= ~rd_ptr_q;
            end
            count_q       <= count_q + {1'b0, push} - {1'b0, pop};
            outstanding_q <= outstanding_q + {1'b0, issue} - {1'b0, rsp};
            if (rsp && (discard_q != 2'd0)) begin
                discard_q <= discard_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: hand-derived vector table, directed redirect/wrap/reset sequences and
// random traffic, all checked against a queue-based reference model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        take_branch = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_gnt_i     (imem_gnt),
        .imem_rvalid_i  (imem_rvalid),
        .imem_rdata_i   (imem_rdata),
        .take_branch_i  (take_branch),
        .branch_target_i(branch_target),
        .instr_valid_o  (instr_valid),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .instr_ready_i  (ready)
    );

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] addr; bit drop; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } entry_t;
    typedef struct {
        logic rst; logic rdy; logic ereq; logic [31:0] eaddr; logic evalid; logic [31:0] epc;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int viol = 0;
    bit regs_known = 0;

    // Memory environment knobs
    bit gnt_val = 1;
    bit mem_en = 1;
    int mem_lat = 1;
    mem_req_t mq[$];

    // Reference model
    flight_t     infl[$];
    entry_t      fifo[$];
    logic [31:0] m_fetch = RST_PC;
    logic [31:0] m_head = RST_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
        bit      exp_valid;
        bit      exp_pop;
        bit      exp_req;
        int      occ;
        flight_t e;
        @(negedge clk);
        rst_n = r;
        ready = rdy;
        take_branch = br;
        branch_target = tgt;
        imem_gnt = gnt_val;
        if (mem_en && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem_word(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata = $urandom;
        end
        #1;
        exp_valid = r && !br && (fifo.size() != 0);
        exp_pop = exp_valid && rdy;
        occ = infl.size() + fifo.size() - (exp_pop ? 1 : 0);
        exp_req = r && !br && (occ < 2);
        chk("model.req", imem_req, exp_req);
        chk("model.valid", instr_valid, exp_valid);
        if (regs_known) begin
            chk("model.addr", imem_addr, m_fetch);
            chk("model.pc", instr_pc, m_head);
        end
        if (exp_valid) chk("model.instr", instr, fifo[0].word);
        // Memory reacts to what the DUT actually presents.
        if (imem_rvalid) void'(mq.pop_front());
        if (imem_req && imem_gnt) mq.push_back(mem_req_t'{imem_addr, cyc + mem_lat});
        if (!r) begin
            m_fetch = RST_PC;
            m_head = RST_PC;
            fifo.delete();
            infl.delete();
        end else if (br) begin
            if (imem_rvalid && infl.size() > 0) void'(infl.pop_front());
            foreach (infl[i]) infl[i].drop = 1'b1;
            fifo.delete();
            m_fetch = {tgt[31:2], 2'b00};
            m_head = {tgt[31:2], 2'b00};
        end else begin
            if (exp_pop) begin
                void'(fifo.pop_front());
                m_head = m_head + 32'd4;
            end
            if (imem_rvalid) begin
                if (infl.size() == 0) begin
                    viol++;
                end else begin
                    e = infl.pop_front();
                    if (!e.drop) fifo.push_back(entry_t'{e.addr, imem_rdata});
                end
            end
            if (exp_req && imem_gnt) begin
                infl.push_back(flight_t'{m_fetch, 1'b0});
                m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    // Hold reset until the memory has returned everything it still owes.
    task automatic do_reset();
        mem_en = 1;
        gnt_val = 1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 8 && mq.size() > 0; k++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    vec_t tbl [16];
    bit   found;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h100};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h100};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h118, 1'b0, 32'h110};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h100};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 32'h100};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};

        step(1'b0, 1'b0, 1'b0, 32'h0);
        regs_known = 1;
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Stream from reset, reset, then backpressure and resume
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].rdy, 1'b0, 32'h0);
            chk($sformatf("tbl%0d.req", i), imem_req, tbl[i].ereq);
            chk($sformatf("tbl%0d.addr", i), imem_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d.valid", i), instr_valid, tbl[i].evalid);
            chk($sformatf("tbl%0d.pc", i), instr_pc, tbl[i].epc);
        end

        // Redirect with two responses in flight
        do_reset();
        mem_lat = 2;
        mem_en = 0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h2002);
        chk("redir.valid", instr_valid, 32'h0);
        chk("redir.req", imem_req, 32'h0);
        mem_en = 1;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir.addr", imem_addr, 32'h2000);
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (instr_valid) begin
                found = 1;
                chk("redir.first_pc", instr_pc, 32'h2000);
                chk("redir.first_instr", instr, mem_word(32'h2000));
            end
        end
        if (!found) chk("redir.timeout", 32'h0, 32'h1);

        // Redirect coincident with rvalid and ready
        do_reset();
        mem_lat = 1;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h3000);
        chk("coinc.valid", instr_valid, 32'h0);
        chk("coinc.req", imem_req, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("coinc.req_next", imem_req, 32'h1);
        chk("coinc.addr0", imem_addr, 32'h3000);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("coinc.addr1", imem_addr, 32'h3004);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("coinc.valid_tgt", instr_valid, 32'h1);
        chk("coinc.pc_tgt", instr_pc, 32'h3000);

        // Wrap-around past the top of the address space
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFD);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap.addr1", imem_addr, 32'h0000_0000);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap.pc0", instr_pc, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap.pc1", instr_pc, 32'h0000_0000);

        // Reset mid-operation with a response still owed
        do_reset();
        mem_lat = 1;
        mem_en = 0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        mem_en = 1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        mem_en = 0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rstmid.req", imem_req, 32'h0);
        chk("rstmid.valid", instr_valid, 32'h0);
        mem_en = 1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rstmid.addr", imem_addr, RST_PC);
        chk("rstmid.late_rvalid_flagged", viol, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rstmid.no_stale_push", instr_valid, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rstmid.pc", instr_pc, RST_PC);
        chk("rstmid.instr", instr, mem_word(RST_PC));

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] tgt;
            gnt_val = ($urandom_range(0, 3) != 0);
            mem_en = ($urandom_range(0, 3) != 0);
            mem_lat = $urandom_range(1, 3);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(1'b1, ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), tgt);
        end
        chk("viol_total", viol, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
